// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Two-entry skid-buffered pipeline register stage carrying a
//                control bundle plus NUM_CH data channels. Supports flush,
//                NOP bubble insertion and a saturating upstream-stall counter.
//                in_ready depends only on local state, Flush and Bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 36,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     Flush,
  input  logic                     Bubble,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int c_bus_w = NUM_CH * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_main_valid, w_main_valid_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl,  w_main_ctrl_nxt;
  logic [c_bus_w-1:0]  r_main_data,  w_main_data_nxt;
  logic                r_skid_valid, w_skid_valid_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl,  w_skid_ctrl_nxt;
  logic [c_bus_w-1:0]  r_skid_data,  w_skid_data_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_in_ready;
  logic                w_pop;
  logic                w_push;
  logic                w_bub_push;
  logic                w_load;
  logic [CTRL_W-1:0]   w_ld_ctrl;
  logic [c_bus_w-1:0]  w_ld_data;

  // Handshake decode: a bubble is a push of a NOP beat, allowed whenever the
  // post-pop occupancy leaves room, and it never coexists with a real push.
  always_comb begin
    w_in_ready = (r_state != ST_TWO) & ~Flush & ~Bubble;
    w_pop      = r_main_valid & out_ready;
    w_push     = in_valid & w_in_ready;
    w_bub_push = Bubble & ~Flush & ((r_state != ST_TWO) | w_pop);
    w_load     = w_push | w_bub_push;
    w_ld_ctrl  = w_bub_push ? '0 : in_ctrl;
    w_ld_data  = w_bub_push ? '0 : in_data;
  end

  // Next-state and next-entry logic; Flush overrides everything else.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_valid_nxt = r_main_valid;
    w_main_ctrl_nxt  = r_main_ctrl;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_ctrl_nxt  = r_skid_ctrl;
    w_skid_data_nxt  = r_skid_data;
    if (Flush) begin
      w_state_nxt      = ST_EMPTY;
      w_main_valid_nxt = 1'b0;
      w_main_ctrl_nxt  = '0;
      w_skid_valid_nxt = 1'b0;
      w_skid_ctrl_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            w_main_valid_nxt = 1'b1;
            w_main_ctrl_nxt  = w_ld_ctrl;
            w_main_data_nxt  = w_ld_data;
            w_state_nxt      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_load && w_pop) begin
            w_main_ctrl_nxt  = w_ld_ctrl;
            w_main_data_nxt  = w_ld_data;
          end else if (w_load) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_ctrl_nxt  = w_ld_ctrl;
            w_skid_data_nxt  = w_ld_data;
            w_state_nxt      = ST_TWO;
          end else if (w_pop) begin
            // Data is intentionally left stale; only ctrl is scrubbed.
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = '0;
            w_state_nxt      = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            if (w_bub_push) begin
              // Skid drains into main and the NOP refills skid.
              w_skid_ctrl_nxt = '0;
              w_skid_data_nxt = '0;
            end else begin
              w_skid_valid_nxt = 1'b0;
              w_state_nxt      = ST_ONE;
            end
          end
        end
        default: begin
          w_state_nxt      = ST_EMPTY;
          w_main_valid_nxt = 1'b0;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_main_ctrl  <= w_main_ctrl_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_ctrl  <= w_skid_ctrl_nxt;
      r_skid_data  <= w_skid_data_nxt;
    end
  end

  // Saturating count of cycles where upstream offers a beat that is refused.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !w_in_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_main_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg: a queue reference
//                model checks every cycle, plus a vector table and directed
//                sequences for streaming, backpressure, bubble, flush,
//                counter saturation and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int CTRL_W  = 36;
  localparam int DATA_W  = 32;
  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 4;
  localparam int BUS_W   = NUM_CH * DATA_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              Clk, Rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, Flush, Bubble;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [BUS_W-1:0]  in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .Flush(Flush), .Bubble(Bubble), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  a_no_overflow:  assert property (@(posedge Clk) disable iff (!Rst_n) !(occupancy == 2'd2 && in_ready));
  a_no_underflow: assert property (@(posedge Clk) disable iff (!Rst_n) !(occupancy == 2'd0 && out_valid));
  a_occ_range:    assert property (@(posedge Clk) disable iff (!Rst_n) occupancy != 2'd3);

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [BUS_W-1:0]  d;
  } beat_t;

  beat_t q[$];
  int    m_stall = 0;
  int    n_deliv = 0;
  logic  m_acc   = 1'b0;

  typedef struct {
    logic iv, ordy, fl, bb;
    logic [CTRL_W-1:0] ctrl;
    logic e_rdy;
    logic [1:0] e_occ;
    logic e_ov;
    logic [CTRL_W-1:0] e_octrl;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [BUS_W-1:0] data_of(input logic [CTRL_W-1:0] c);
    logic [BUS_W-1:0] d;
    for (int k = 0; k < NUM_CH; k++)
      d[k*DATA_W +: DATA_W] = (c[31:0] * 32'h9E37_79B9) ^ (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    return d;
  endfunction

  function automatic vec_t mk(input logic iv, ordy, fl, bb, input int c,
                              input logic e_rdy, input int e_occ, input logic e_ov, input int e_octrl);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.bb = bb; v.ctrl = CTRL_W'(c);
    v.e_rdy = e_rdy; v.e_occ = 2'(e_occ); v.e_ov = e_ov; v.e_octrl = CTRL_W'(e_octrl);
    return v;
  endfunction

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, ordy, fl, bb, input logic [CTRL_W-1:0] c);
    in_valid = iv; out_ready = ordy; Flush = fl; Bubble = bb;
    in_ctrl = c; in_data = data_of(c);
  endtask

  // Compare the DUT against the reference queue, then advance the model to
  // what the coming rising edge should produce.
  task automatic sb_eval();
    logic m_rdy, m_pop, m_push, m_bub;
    int   sz;
    beat_t b;
    sz    = q.size();
    m_rdy = (sz != 2) && !Flush && !Bubble;
    chk("in_ready",  in_ready,  m_rdy);
    chk("occupancy", occupancy, sz);
    chk("out_valid", out_valid, sz != 0);
    chk("stall_cnt", stall_cnt, m_stall);
    if (sz != 0) begin
      chk("out_ctrl", out_ctrl, q[0].c);
      chk("out_data", out_data, q[0].d);
    end else begin
      chk("empty_ctrl", out_ctrl, 0);
    end
    m_pop  = (sz != 0) && out_ready;
    m_push = in_valid && m_rdy;
    m_bub  = Bubble && !Flush && ((sz - int'(m_pop)) < 2);
    if (in_valid && !m_rdy && m_stall != CNT_MAX) m_stall++;
    m_acc = m_push;
    if (m_pop) begin
      void'(q.pop_front());
      n_deliv++;
    end
    if (Flush) q.delete();
    else if (m_bub) begin
      b.c = '0; b.d = '0; q.push_back(b);
    end else if (m_push) begin
      b.c = in_ctrl; b.d = in_data; q.push_back(b);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    sb_eval();
    @(posedge Clk);
    #1;
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic reset_pulse(input logic check_now);
    drive(0, 0, 0, 0, '0);
    #1 Rst_n = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl",  out_ctrl,  0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_stall_cnt", stall_cnt, 0);
    end
    #1 Rst_n = 1'b1;
    q.delete();
    m_stall = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0;
    logic done;

    tbl[0]  = mk(1,1,0,0, 1, 1,1,1, 1);
    tbl[1]  = mk(1,1,0,0, 2, 1,1,1, 2);
    tbl[2]  = mk(1,0,0,0, 3, 1,2,1, 2);
    tbl[3]  = mk(1,0,0,0, 4, 0,2,1, 2);
    tbl[4]  = mk(1,1,0,0, 4, 0,1,1, 3);
    tbl[5]  = mk(1,1,0,0, 4, 1,1,1, 4);
    tbl[6]  = mk(0,1,0,0, 0, 1,0,0, 0);
    tbl[7]  = mk(0,1,0,1, 0, 0,1,1, 0);
    tbl[8]  = mk(1,0,0,0, 5, 1,2,1, 0);
    tbl[9]  = mk(1,0,1,0, 6, 0,0,0, 0);
    tbl[10] = mk(1,1,0,0, 7, 1,1,1, 7);
    tbl[11] = mk(1,0,0,1, 8, 0,2,1, 7);
    tbl[12] = mk(1,0,0,1, 8, 0,2,1, 7);
    tbl[13] = mk(1,1,0,1, 8, 0,2,1, 0);
    tbl[14] = mk(1,1,0,0, 8, 0,1,1, 0);
    tbl[15] = mk(1,1,0,0, 8, 1,1,1, 8);
    tbl[16] = mk(0,1,0,0, 0, 1,0,0, 0);

    Rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    #2;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_ctrl",  out_ctrl,  0);
    chk("init_out_data",  out_data,  0);
    chk("init_occupancy", occupancy, 0);
    chk("init_in_ready",  in_ready,  1);
    chk("init_stall_cnt", stall_cnt, 0);
    @(posedge Clk);
    #3 Rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].bb, tbl[i].ctrl);
      @(negedge Clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      sb_eval();
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_occ", i),   occupancy, tbl[i].e_occ);
      chk($sformatf("vec%0d_ov", i),    out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_octrl", i), out_ctrl,  tbl[i].e_octrl);
    end

    // Streaming at full throughput.
    reset_pulse(1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, CTRL_W'(i));
      step();
      chk("stream_ctrl", out_ctrl, i);
      chk("stream_occ",  occupancy, 1);
    end
    chk("stream_stall", stall_cnt, 0);
    drive(0, 1, 0, 0, '0);
    step();

    // Backpressure: A, B held, C stalled, then drained in order.
    d0 = n_deliv;
    drive(1, 0, 0, 0, 36'd100); step();
    drive(1, 0, 0, 0, 36'd101); step();
    chk("bp_occ", occupancy, 2);
    drive(1, 0, 0, 0, 36'd102);
    for (int i = 0; i < 3; i++) begin
      s0 = int'(stall_cnt);
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall_inc", stall_cnt, s0 + 1);
    end
    drive(1, 1, 0, 0, 36'd102);
    done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      step();
      done = m_acc;
    end
    chk("bp_c_accepted", done, 1);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 4 && q.size() != 0; i++) step();
    step();
    chk("bp_delivered", n_deliv - d0, 3);

    // Bubble in ONE with pop, upstream beat follows.
    drive(1, 1, 0, 0, 36'd200); step();
    drive(1, 1, 0, 1, 36'd201); step();
    chk("bub_ov",    out_valid, 1);
    chk("bub_ctrl",  out_ctrl,  0);
    chk("bub_data",  out_data,  0);
    drive(1, 1, 0, 0, 36'd201); step();
    chk("bub_next_ctrl", out_ctrl, 201);
    drive(0, 1, 0, 0, '0); step();

    // Stall counter saturation.
    reset_pulse(1'b0);
    drive(1, 0, 0, 0, 36'd500); step();
    drive(1, 0, 0, 0, 36'd501); step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sat_cnt", stall_cnt, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end

    // Flush in TWO with an incoming beat; nothing survives.
    drive(1, 0, 1, 0, 36'd600); step();
    chk("flush_occ",  occupancy, 0);
    chk("flush_ov",   out_valid, 0);
    chk("flush_ctrl", out_ctrl,  0);
    chk("flush_keeps_stall", stall_cnt, CNT_MAX);

    // Asynchronous reset while in TWO, then first push after release.
    drive(1, 0, 0, 0, 36'd700); step();
    drive(1, 0, 0, 0, 36'd701); step();
    chk("pre_rst_occ", occupancy, 2);
    reset_pulse(1'b1);
    drive(1, 1, 0, 0, 36'd702); step();
    chk("post_rst_ov",   out_valid, 1);
    chk("post_rst_ctrl", out_ctrl,  702);
    drive(0, 1, 0, 0, '0); step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
Parameters:
REQ-001 SHALL have parameter CTRL_W, default 36, control-bundle width.
REQ-002 SHALL have parameter DATA_W, default 32, width of one data channel.
REQ-003 SHALL have parameter NUM_CH, default 8, number of data channels.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.

Ports:
REQ-005 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  stage accepts a beat this cycle.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 SHALL have port in_data  input  NUM_CH*DATA_W  upstream data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port out_valid  output  1  downstream beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  registered control bundle.
REQ-014 SHALL have port out_data  output  NUM_CH*DATA_W  registered data.
REQ-015 SHALL have port Flush  input  1  discard all held and incoming beats.
REQ-016 SHALL have port Bubble  input  1  insert a NOP beat and stall upstream.
REQ-017 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-018 SHALL have port stall_cnt  output  CNT_W  saturating count of upstream stall cycles.

Function
REQ-019 SHALL hold two entries, MAIN (drives out_*) and SKID, each with ctrl, data and valid fields.
REQ-020 SHALL keep state EMPTY/ONE/TWO, encoded as occupancy 0/1/2.
REQ-021 SHALL drive in_ready = (occupancy != 2) & !Flush & !Bubble, with no combinational path from out_ready.
REQ-022 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-023 SHALL drive out_valid = MAIN.valid, and out_ctrl/out_data directly from MAIN registers.
REQ-024 SHALL, in EMPTY, on push, load the input into MAIN and move to ONE.
REQ-025 SHALL, in ONE, on push without pop, load the input into SKID and move to TWO.
REQ-026 SHALL, in ONE, on push with pop, load the input into MAIN and stay in ONE.
REQ-027 SHALL, in ONE, on pop without push, move to EMPTY and clear MAIN.ctrl to 0; MAIN data is held.
REQ-028 SHALL, in TWO, on pop, copy SKID into MAIN and move to ONE; push cannot occur in TWO.
REQ-029 SHALL give latency of 1 cycle from push to out_valid when EMPTY; zero bubbles at full throughput with out_ready held 1.
REQ-030 SHALL, on Bubble=1 with Flush=0 and the post-pop occupancy < 2, push a NOP beat (ctrl=0, data=0, valid=1) by the same rules as a normal push; the input is not accepted.
REQ-031 SHALL ignore Bubble (no NOP, in_ready still 0) when occupancy is 2 and no pop occurs.
REQ-032 SHALL, on Flush=1, clear both valid bits and both ctrl fields, and set occupancy to 0 at the next edge.
REQ-033 SHALL, on Flush, discard the incoming beat; a pop in the same cycle still counts as delivered downstream.
REQ-034 SHALL apply priority Flush > Bubble > normal push.
REQ-035 SHALL increment stall_cnt in every cycle with in_valid=1 and in_ready=0, saturating at 2^CNT_W-1 (no wrap); Flush does not clear it.
REQ-036 SHALL never overflow (push in TWO) or underflow (pop in EMPTY); these are assertion targets.

Reset
REQ-037 SHALL, while Rst_n=0, asynchronously force occupancy=0, both valid bits=0, all ctrl/data fields=0 and stall_cnt=0, giving out_valid=0, out_ctrl=0, out_data=0 and in_ready=1.
REQ-038 SHALL, on reset assertion mid-transfer, lose all held beats; after release it is EMPTY with the first push accepted on the first rising edge.

Verification
REQ-039 SHALL pass streaming: in_valid=1 and out_ready=1 for 10 cycles with ctrl=i -> out_ctrl = 0..9 on consecutive cycles, occupancy stays 1, stall_cnt=0.
REQ-040 SHALL pass backpressure: out_ready=0 while pushing beats A, B, C -> A and B held, occupancy=2, in_ready=0, C held upstream, stall_cnt increments per cycle; then out_ready=1 -> A, B, C delivered in order with none lost or duplicated.
REQ-041 SHALL pass bubble: Bubble=1 for one cycle in ONE with pop -> next out beat has ctrl=0, data=0, valid=1; the upstream beat is delivered on the following cycle.
REQ-042 SHALL pass flush: Flush=1 in TWO while in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, incoming beat dropped.
REQ-043 SHALL pass saturation (CNT_W=4): upstream stalled for 20 cycles -> stall_cnt reaches 15 and holds 15.
REQ-044 SHALL pass async reset: Rst_n pulsed low between clock edges while in TWO -> outputs zero immediately, before the next edge; in_ready=1 after release.
